system: RTL and testbench

// Top-level ack-paced serial message sender for the ARC board bring-up system.

---
 rtl/system.sv | 141 ++++++++++++++
 tb/tb_system.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/system.sv
// Ack-paced serial message sender: each rx rising edge queues one byte
// of a fixed 8-byte message, sent as an 8N1 UART frame on tx.
`timescale 1ns/1ps
module system #(
   parameter int clk_freq = 50_000_000,
   parameter int baud     = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic tx
);

   localparam int DIV = clk_freq / baud;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic          s1;
   logic          s2;
   logic          prev;
   logic          rx_edge;
   logic          go;
   logic          tick;
   logic [3:0]    pending;
   logic [2:0]    msg_idx;
   logic [2:0]    bit_cnt;
   logic [CW-1:0] baud_cnt;
   logic [7:0]    shreg;

   function automatic logic [7:0] rom(input logic [2:0] i);
      logic [7:0] b;
      case (i)
         3'd0: b = 8'h41;
         3'd1: b = 8'h52;
         3'd2: b = 8'h43;
         3'd3: b = 8'h2D;
         3'd4: b = 8'h4F;
         3'd5: b = 8'h4B;
         3'd6: b = 8'h0D;
         3'd7: b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign rx_edge = s2 & ~prev;
   assign go      = (state == IDLE) && (pending != 4'd0);
   assign tick    = (baud_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= rx;
         s2   <= s1;
         prev <= s2;
      end
   end

   // Edge and frame start in the same cycle cancel out, even when full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 4'd0;
      end else begin
         case ({rx_edge, go})
            2'b10: if (pending != 4'hF) pending <= pending + 4'd1;
            2'b01: pending <= pending - 4'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         msg_idx  <= 3'd0;
         bit_cnt  <= 3'd0;
         baud_cnt <= '0;
         shreg    <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= 3'd0;
               if (go) begin
                  shreg   <= rom(msg_idx);
                  msg_idx <= msg_idx + 3'd1;
                  tx      <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (tick) begin
                  baud_cnt <= '0;
                  tx       <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_system.sv
// Bench for system: scoreboard of expected message bytes checked
// against frames decoded from tx.
`timescale 1ns/1ps
module tb_system;

   localparam int DIV = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b0;
   logic tx;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int m_idx = 0;
   int last_k = 0;
   int last_fall = 0;
   int prev_fall = 0;
   bit got;

   logic [7:0] exp_q[$];
   logic [7:0] rom_m [8] = '{8'h41, 8'h52, 8'h43, 8'h2D,
                             8'h4F, 8'h4B, 8'h0D, 8'h0A};

   system #(
      .clk_freq(50_000_000),
      .baud(1_000_000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tx(tx)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Model: queue length is the request backlog, capped at 15.
   task automatic pulse(input int hi, input int lo);
      @(negedge clk);
      rx = 1'b1;
      last_k = cyc + 1;
      if (exp_q.size() < 15) begin
         exp_q.push_back(rom_m[m_idx]);
         m_idx = (m_idx + 1) % 8;
      end
      repeat (hi) @(negedge clk);
      rx = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic wait_fall(input int tmo, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < tmo; n++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            last_fall = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic recv(input string tag);
      bit         ok;
      logic [7:0] b;
      logic [7:0] e;
      b = 8'h00;
      e = 8'h00;
      wait_fall(2000, ok);
      chk({tag, "_start"}, int'(ok), 1);
      if (ok) begin
         if (exp_q.size() == 0) chk({tag, "_qempty"}, 0, 1);
         else e = exp_q.pop_front();
         repeat (DIV / 2) @(negedge clk);
         chk({tag, "_sbit"}, int'(tx), 0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
         end
         repeat (DIV) @(negedge clk);
         chk({tag, "_stop"}, int'(tx), 1);
         chk({tag, "_byte"}, int'(b), int'(e));
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #5;
      chk({tag, "_rst_tx"}, int'(tx), 1);
      #140;
      rst = 1'b1;
      exp_q.delete();
      m_idx = 0;
      @(negedge clk);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // T1: reset and idle
      #1 rst = 1'b0;
      #4;
      chk("t1_rst_tx", int'(tx), 1);
      #140 rst = 1'b1;
      @(negedge clk);
      wait_fall(300, got);
      chk("t1_idle", int'(got), 0);

      // T2: single request, latency and byte
      fork
         pulse(2, 2);
      join_none
      recv("t2");
      chk("t2_lat", last_fall - last_k, 3);

      // T3: queued requests, back-to-back frames
      do_reset("t3");
      fork
         begin
            for (int i = 0; i < 5; i++) pulse(2, 10);
         end
      join_none
      for (int i = 0; i < 5; i++) begin
         recv($sformatf("t3_%0d", i));
         if (i > 0)
            chk($sformatf("t3_gap%0d", i), last_fall - prev_fall,
                10 * DIV + 1);
         prev_fall = last_fall;
      end
      wait_fall(1200, got);
      chk("t3_drain", int'(got), 0);

      // T4: reset mid frame 2
      do_reset("t4a");
      fork
         begin
            pulse(2, 10);
            pulse(2, 10);
            pulse(2, 10);
         end
      join_none
      recv("t4_f1");
      wait_fall(2000, got);
      chk("t4_f2", int'(got), 1);
      repeat (60) @(negedge clk);
      chk("t4_mid_tx", int'(tx), 0);
      rst = 1'b0;
      #5;
      chk("t4_abort_tx", int'(tx), 1);
      #140 rst = 1'b1;
      exp_q.delete();
      m_idx = 0;
      @(negedge clk);
      wait_fall(1200, got);
      chk("t4_pend0", int'(got), 0);
      fork
         pulse(2, 2);
      join_none
      recv("t4_restart");

      // T5: nine single requests, index wraps
      do_reset("t5");
      for (int i = 0; i < 9; i++) begin
         repeat (40) @(negedge clk);
         fork
            pulse(2, 2);
         join_none
         recv($sformatf("t5_%0d", i));
      end

      // T6: burst saturates backlog at 15
      do_reset("t6");
      fork
         begin
            pulse(2, 2);
            repeat (10) @(negedge clk);
            for (int i = 0; i < 20; i++) pulse(2, 2);
         end
      join_none
      for (int i = 0; i < 16; i++) recv($sformatf("t6_%0d", i));
      wait_fall(1200, got);
      chk("t6_extra", int'(got), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
